mac_seq: RTL and testbench



---
 rtl/mac_seq_pkg.sv | 22 ++
 rtl/mac_seq_if.sv | 32 +++
 rtl/mac_seq.sv | 109 ++++++++++
 tb/tb_mac_seq.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mac_seq_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mac_pkg : shared constants and state encoding for the MAC seq.   |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
package mac_pkg;

  localparam int MAC_N_TAPS = 16;
  localparam int MAC_CNT_W  = 4;
  localparam int MAC_ACC_W  = 20;
  localparam int MAC_SETTLE = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_CAP   = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mac_seq_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mac_seq_if : sequencer <-> MAC / test-logic signal bundle.       |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
interface mac_seq_if #(
  parameter int CNT_W = mac_pkg::MAC_CNT_W,
  parameter int ACC_W = mac_pkg::MAC_ACC_W
) ();

  logic             start;
  logic             abort;
  logic [ACC_W-1:0] mac_out;
  logic [CNT_W-1:0] cnt;
  logic             mac_clr;
  logic             busy;
  logic             done;
  logic [ACC_W-1:0] result;
  logic [7:0]       run_cnt;

  modport master (
    input  start, abort, mac_out,
    output cnt, mac_clr, busy, done, result, run_cnt
  );

  modport slave (
    output start, abort, mac_out,
    input  cnt, mac_clr, busy, done, result, run_cnt
  );

endinterface
`default_nettype wire

// File: rtl/mac_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mac_seq : clears the MAC, sweeps the tap index, captures the sum. |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module mac_seq
  import mac_pkg::*;
#(
  parameter int N_TAPS = MAC_N_TAPS,
  parameter int CNT_W  = MAC_CNT_W,
  parameter int ACC_W  = MAC_ACC_W,
  parameter int SETTLE = MAC_SETTLE
) (
  input  wire           clk,
  input  wire           reset,
  mac_seq_if.master     bus
);

  // Settle counter holds SETTLE-1 down to 0.
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [SET_W-1:0]   settle_q;
  logic               mac_clr_q;
  logic               busy_q;
  logic               done_q;
  logic [ACC_W-1:0]   result_q;
  logic [7:0]         run_cnt_q;

  logic               abortable;
  assign abortable = (state_q == ST_CLEAR) || (state_q == ST_RUN) || (state_q == ST_WAIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      settle_q  <= '0;
      mac_clr_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      run_cnt_q <= 8'd0;
    end else begin
      done_q    <= 1'b0;
      mac_clr_q <= 1'b0;
      if (bus.abort && abortable) begin
        // Flush the partial sum with a one-cycle clear on the way out.
        state_q   <= ST_IDLE;
        cnt_q     <= '0;
        busy_q    <= 1'b0;
        mac_clr_q <= 1'b1;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            if (bus.start && !bus.abort) begin
              state_q   <= ST_CLEAR;
              mac_clr_q <= 1'b1;
              busy_q    <= 1'b1;
            end
          end
          ST_CLEAR: begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
          end
          ST_RUN: begin
            if (cnt_q == CNT_W'(N_TAPS - 1)) begin
              state_q  <= ST_WAIT;
              settle_q <= SET_W'(SETTLE - 1);
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          ST_WAIT: begin
            if (settle_q == '0) begin
              state_q   <= ST_CAP;
              result_q  <= bus.mac_out;
              done_q    <= 1'b1;
              run_cnt_q <= run_cnt_q + 8'd1;
            end else begin
              settle_q <= settle_q - 1'b1;
            end
          end
          ST_CAP: begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.cnt     = cnt_q;
  assign bus.mac_clr = mac_clr_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.result  = result_q;
  assign bus.run_cnt = run_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mac_seq : directed bench for mac_seq with a behavioural MAC.  |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module tb_mac_seq;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  int   n_done;
  int   exp_runs;

  mac_seq_if bus ();

  mac_seq u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MAC model: registered product stage, then accumulate; each index counted once per clear.
  logic [7:0]  mem [16];
  logic [15:0] seen;
  logic [15:0] prod;
  logic        prod_v;
  logic [19:0] acc;

  always_ff @(posedge clk) begin
    if (bus.mac_clr) begin
      acc    <= '0;
      prod_v <= 1'b0;
      seen   <= '0;
      prod   <= '0;
    end else begin
      prod_v <= bus.busy && !seen[bus.cnt];
      prod   <= 16'(mem[bus.cnt]) * 16'(mem[bus.cnt]);
      if (bus.busy) seen[bus.cnt] <= 1'b1;
      if (prod_v) acc <= acc + 20'(prod);
    end
  end
  assign bus.mac_out = acc;

  always @(negedge clk) if (bus.done) n_done++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 16; i++) mem[i] = v;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_cnt(input int v);
    int n;
    n = 0;
    while (!(bus.busy && !bus.mac_clr && 32'(bus.cnt) == v) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("cnt_timeout", 32'd1, 32'd0);
  endtask

  // One full run from a start pulse, checking the cycle-exact schedule.
  task automatic run_check(input logic [19:0] exp_res, input bit poke_start);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("clr_cycle_mac_clr", 32'(bus.mac_clr), 32'd1);
    check("clr_cycle_busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (poke_start) bus.start = (i == 3);
      check("run_cnt_idx", 32'(bus.cnt), 32'(i));
      check("run_no_done", 32'(bus.done) | 32'(bus.mac_clr), 32'd0);
    end
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("wait_cnt_hold", 32'(bus.cnt), 32'd15);
      check("wait_no_done", 32'(bus.done), 32'd0);
    end
    @(negedge clk);
    exp_runs = (exp_runs + 1) % 256;
    check("cap_done", 32'(bus.done), 32'd1);
    check("cap_busy", 32'(bus.busy), 32'd1);
    check("cap_result", 32'(bus.result), 32'(exp_res));
    check("cap_run_cnt", 32'(bus.run_cnt), 32'(exp_runs));
    @(negedge clk);
    check("post_done_low", 32'(bus.done), 32'd0);
    check("post_busy_low", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("stay_idle", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int d0, t1, t2, cyc, got;
    n_vec = 0; n_err = 0; n_done = 0; exp_runs = 0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    fill(8'd1);
    reset = 1'b1;
    #1;
    check("rst_cnt", 32'(bus.cnt), 32'd0);
    check("rst_mac_clr", 32'(bus.mac_clr), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_run_cnt", 32'(bus.run_cnt), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("idle_mac_clr_low", 32'(bus.mac_clr), 32'd0);

    run_check(20'd16, 1'b0);
    fill(8'd255);
    run_check(20'hFE010, 1'b0);
    fill(8'd1);
    run_check(20'd16, 1'b0);

    // Abort at cnt=5.
    d0 = n_done;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_cnt(5);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_mac_clr", 32'(bus.mac_clr), 32'd1);
    check("abort_cnt", 32'(bus.cnt), 32'd0);
    @(negedge clk);
    check("abort_clr_pulse_end", 32'(bus.mac_clr), 32'd0);
    check("abort_result_kept", 32'(bus.result), 32'd16);
    check("abort_run_cnt_kept", 32'(bus.run_cnt), 32'(exp_runs));
    repeat (25) @(negedge clk);
    check("abort_no_done", 32'(n_done - d0), 32'd0);

    run_check(20'd16, 1'b1);

    // Start held: back-to-back runs, done 21 cycles apart.
    t1 = -1; t2 = -1; got = 0;
    @(negedge clk);
    bus.start = 1'b1;
    for (cyc = 1; cyc <= 50; cyc++) begin
      @(negedge clk);
      if (bus.done) begin
        got++;
        if (t1 < 0) t1 = cyc; else if (t2 < 0) t2 = cyc;
      end
    end
    bus.start = 1'b0;
    check("held_done_count", 32'(got), 32'd2);
    check("held_first_done", 32'(t1), 32'd20);
    check("held_done_gap", 32'(t2 - t1), 32'd21);
    wait_idle();
    exp_runs = exp_runs + 3;
    check("held_run_cnt", 32'(bus.run_cnt), 32'(exp_runs));

    // Reset mid-run at cnt=7.
    d0 = n_done;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_cnt(7);
    #2;
    reset = 1'b1;
    #1;
    check("mrst_cnt", 32'(bus.cnt), 32'd0);
    check("mrst_mac_clr", 32'(bus.mac_clr), 32'd1);
    check("mrst_busy", 32'(bus.busy), 32'd0);
    check("mrst_result", 32'(bus.result), 32'd0);
    check("mrst_run_cnt", 32'(bus.run_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (22) @(negedge clk);
    check("mrst_no_done", 32'(n_done - d0), 32'd0);
    exp_runs = 0;
    run_check(20'd16, 1'b0);

    // 255 more runs wrap run_cnt to 0.
    got = 0;
    cyc = 0;
    bus.start = 1'b1;
    while (got < 255 && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      if (bus.done) got++;
      if (got == 255) bus.start = 1'b0;
    end
    bus.start = 1'b0;
    check("wrap_runs", 32'(got), 32'd255);
    wait_idle();
    check("wrap_run_cnt", 32'(bus.run_cnt), 32'd0);

    // start and abort together in IDLE.
    bus.start = 1'b1;
    bus.abort = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("sa_busy", 32'(bus.busy), 32'd0);
      check("sa_mac_clr", 32'(bus.mac_clr), 32'd0);
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
